// File: rtl/mult_seq_csa_if.sv
// ---------------------------------------------------------------------------
// mult_seq_csa_if: handshake bundle for mult_seq_csa (sgn only with MULT_SEQ_CSA_SIGNED_EN). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mult_seq_csa_if #(
  parameter int WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
`ifdef MULT_SEQ_CSA_SIGNED_EN
  logic               sgn;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] o;
  logic               busy;

  modport master (
    output in_valid, x, y,
`ifdef MULT_SEQ_CSA_SIGNED_EN
    output sgn,
`endif
    output out_ready,
    input  in_ready, out_valid, o, busy
  );

  modport slave (
    input  in_valid, x, y,
`ifdef MULT_SEQ_CSA_SIGNED_EN
    input  sgn,
`endif
    input  out_ready,
    output in_ready, out_valid, o, busy
  );
endinterface

`default_nettype wire

// File: rtl/mult_seq_csa.sv
// ---------------------------------------------------------------------------
// mult_seq_csa: K bits/cycle carry-save multiplier with Kogge-Stone resolve.
// MULT_SEQ_CSA_SIGNED_EN adds Baugh-Wooley two's-complement mode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_seq_csa #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_csa_if.slave   bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int N  = WIDTH / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LV = $clog2(W2);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t          state;
  logic [W2-1:0]   x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [W2-1:0]   s_acc;
  logic [W2-1:0]   c_acc;
  logic [W2-1:0]   s_nxt;
  logic [W2-1:0]   c_nxt;
  logic [W2-1:0]   sum_ks;
  logic [W2-1:0]   o_r;
  logic [CW-1:0]   cnt;
  logic            out_valid_r;
  logic            busy_r;
  logic            last_step;
  logic            cin;
`ifdef MULT_SEQ_CSA_SIGNED_EN
  logic            sgn_q;
  assign cin = sgn_q;
`else
  assign cin = 1'b0;
`endif

  assign last_step     = (cnt == CW'(N - 1));
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.o         = o_r;
  assign bus.busy      = busy_r;

  // x_sh/y_sh are pre-shifted each step, so row j always sits at x_sh << j.
  always_comb begin
    logic [W2-1:0] ps;
    logic [W2-1:0] pc;
    logic [W2-1:0] pp;
    logic [W2-1:0] sm;
    ps = s_acc;
    pc = c_acc;
    pp = '0;
    sm = '0;
    for (int j = 0; j < K; j++) begin
      pp = y_sh[j] ? (x_sh << j) : '0;
`ifdef MULT_SEQ_CSA_SIGNED_EN
      // Sign row carries weight -2^(WIDTH-1): add ~row now, the +1 enters as cin in ADD.
      if (sgn_q && last_step && (j == K - 1)) pp = ~pp;
`endif
      sm = ps ^ pc ^ pp;
      pc = ((ps & pc) | (ps & pp) | (pc & pp)) << 1;
      ps = sm;
    end
    s_nxt = ps;
    c_nxt = pc;
  end

  // Kogge-Stone carry network; gg[i] is the carry out of bit i including cin.
  always_comb begin
    logic [W2-1:0] hp;
    logic [W2-2:0] gg;
    logic [W2-2:0] pg;
    logic [W2-2:0] gn;
    logic [W2-2:0] pn;
    hp = s_acc ^ c_acc;
    gg = (s_acc[W2-2:0] & c_acc[W2-2:0]) | {{(W2-2){1'b0}}, hp[0] & cin};
    pg = hp[W2-2:0];
    for (int l = 0; l < LV; l++) begin
      gn = gg;
      pn = pg;
      for (int i = (1 << l); i < W2 - 1; i++) begin
        gn[i] = gg[i] | (pg[i] & gg[i - (1 << l)]);
        pn[i] = pg[i] & pg[i - (1 << l)];
      end
      gg = gn;
      pg = pn;
    end
    sum_ks = hp ^ {gg, cin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_sh        <= '0;
      y_sh        <= '0;
      s_acc       <= '0;
      c_acc       <= '0;
      cnt         <= '0;
      o_r         <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef MULT_SEQ_CSA_SIGNED_EN
      sgn_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
`ifdef MULT_SEQ_CSA_SIGNED_EN
            x_sh  <= {{WIDTH{bus.sgn & bus.x[WIDTH-1]}}, bus.x};
            sgn_q <= bus.sgn;
`else
            x_sh  <= {{WIDTH{1'b0}}, bus.x};
`endif
            y_sh   <= bus.y;
            s_acc  <= '0;
            c_acc  <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          s_acc <= s_nxt;
          c_acc <= c_nxt;
          x_sh  <= x_sh << K;
          y_sh  <= y_sh >> K;
          cnt   <= cnt + CW'(1);
          if (last_step) state <= ADD;
        end
        ADD: begin
          o_r         <= sum_ks;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mult_seq_csa.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_csa: directed + randomized checks of mult_seq_csa against a product model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_seq_csa;
  localparam int W    = 8;
  localparam int KK   = 2;
  localparam int L    = W / KK + 1;
  localparam int NOPS = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_csa_if #(.WIDTH(W))  bus ();
  mult_seq_csa_if #(.WIDTH(16)) bw1 ();
  mult_seq_csa_if #(.WIDTH(16)) bw16 ();

  mult_seq_csa #(.WIDTH(W),  .K(KK)) dut      (.clk(clk), .rst(rst), .bus(bus));
  mult_seq_csa #(.WIDTH(16), .K(1))  dut_k1   (.clk(clk), .rst(rst), .bus(bw1));
  mult_seq_csa #(.WIDTH(16), .K(16)) dut_k16  (.clk(clk), .rst(rst), .bus(bw16));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_done   = 0;
  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Plain arithmetic product, sign-extending both operands when s is set.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = {{W{s & a[W-1]}}, a};
    eb = {{W{s & b[W-1]}}, b};
    return ea * eb;
  endfunction

  // Scoreboard: outputs checked every cycle at the falling edge.
  initial begin
    logic was_valid;
    logic s_cur;
    was_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready_in_reset", bus.in_ready, 1'b0);
        n_acc -= exp_q.size();
        exp_q.delete();
        acc_q.delete();
        was_valid = 1'b0;
      end else begin
        chk("busy", bus.busy, exp_q.size() != 0);
        chk("in_ready", bus.in_ready, exp_q.size() == 0);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", bus.out_valid, 1'b0);
          end else begin
            chk("o_vs_model", bus.o, exp_q[0]);
            if (!was_valid) chk("latency", cyc - acc_q[0], L);
          end
        end
        was_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          n_done++;
          was_valid = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
`ifdef MULT_SEQ_CSA_SIGNED_EN
          s_cur = bus.sgn;
`else
          s_cur = 1'b0;
`endif
          exp_q.push_back(model(bus.x, bus.y, s_cur));
          acc_q.push_back(cyc + 1);
          n_acc++;
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] lit, input int hold, input string nm);
    int t;
    bus.x = a;
    bus.y = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk(nm, bus.o, lit);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({nm, "_held"}, bus.o, lit);
      chk({nm, "_valid_held"}, bus.out_valid, 1'b1);
      chk({nm, "_no_ready"}, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_ready_after"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    int lat1;
    int lat16;
    int t;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b0;
    bw1.in_valid = 1'b0; bw1.x = '0; bw1.y = '0; bw1.out_ready = 1'b1;
    bw16.in_valid = 1'b0; bw16.x = '0; bw16.y = '0; bw16.out_ready = 1'b1;
`ifdef MULT_SEQ_CSA_SIGNED_EN
    bus.sgn = 1'b0; bw1.sgn = 1'b0; bw16.sgn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o", bus.o, '0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready_after", bus.in_ready, 1'b1);

    do_op(8'hFF, 8'hFF, 16'hFE01, 0, "ff_x_ff");
    do_op(8'h00, 8'hA5, 16'h0000, 0, "00_x_a5");
    do_op(8'h01, 8'h80, 16'h0080, 0, "01_x_80");
    do_op(8'h12, 8'h34, 16'h03A8, 10, "backpressure");

    // Reset during the second MUL cycle discards the operation.
    bus.x = 8'h33; bus.y = 8'h44; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("no_valid_after_rst", bus.out_valid, 1'b0);
      @(posedge clk); #1;
    end
    do_op(8'h0F, 8'h0F, 16'h00E1, 0, "0f_x_0f");

`ifdef MULT_SEQ_CSA_SIGNED_EN
    bus.sgn = 1'b1;
    do_op(8'h80, 8'h80, 16'h4000, 0, "s_80_x_80");
    do_op(8'hFF, 8'h01, 16'hFFFF, 0, "s_ff_x_01");
    do_op(8'h7F, 8'h80, 16'hC080, 0, "s_7f_x_80");
    bus.sgn = 1'b0;
    do_op(8'h80, 8'h80, 16'h4000, 0, "u_80_x_80");
    do_op(8'hFF, 8'h01, 16'h00FF, 0, "u_ff_x_01");
`endif

    // 16-bit instances at the K extremes, launched on the same edge.
    bw1.x = 16'hFFFF; bw1.y = 16'hFFFF; bw1.in_valid = 1'b1;
    bw16.x = 16'hFFFF; bw16.y = 16'hFFFF; bw16.in_valid = 1'b1;
    chk("k1_in_ready", bw1.in_ready, 1'b1);
    chk("k16_in_ready", bw16.in_ready, 1'b1);
    @(posedge clk); #1;
    bw1.in_valid = 1'b0; bw16.in_valid = 1'b0;
    lat1 = -1; lat16 = -1;
    for (int tt = 0; tt < 40 && (lat1 < 0 || lat16 < 0); tt++) begin
      if (bw1.out_valid && lat1 < 0) begin
        lat1 = tt;
        chk("k1_o", bw1.o, 32'hFFFE0001);
      end
      if (bw16.out_valid && lat16 < 0) begin
        lat16 = tt;
        chk("k16_o", bw16.o, 32'hFFFE0001);
      end
      @(posedge clk); #1;
    end
    chk("k1_latency", lat1, 17);
    chk("k16_latency", lat16, 2);

    // Random traffic with gaps on both sides of the handshake.
    t = n_acc;
    for (int c = 0; c < 40000 && (n_acc - t) < NOPS; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.x         = W'($urandom);
      bus.y         = W'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef MULT_SEQ_CSA_SIGNED_EN
      bus.sgn       = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    t = 0;
    while ((bus.busy || bus.out_valid) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_idle", bus.busy, 1'b0);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("results_vs_accepts", n_done, n_acc);
    chk("random_ops_reached", (n_acc - lat1 * 0) >= NOPS, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=%0d cycles required=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
